// File: rtl/pwm_pkg.sv
// Shared state encoding and reset constants for the PWM scheduler.
// State constants are plain localparams so older code can reference them without the enum.
package pwm_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      DRAIN = ST_DRAIN
   } pwm_state_e;

   // Period registers reset to all ones, duty registers to zero (replicated to BITS by the user).
   localparam logic PERIOD_RST_BIT = 1'b1;
   localparam logic DUTY_RST_BIT   = 1'b0;

endpackage

// File: rtl/pwm_period_counter.sv
// Shared period counter: counts 0..period and flags the wrap cycle (cnt == period while enabled).
// clr has priority over en and forces the count back to zero.
module pwm_period_counter #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            en,
   input  logic            clr,
   input  logic [BITS-1:0] period,
   output logic [BITS-1:0] cnt,
   output logic            wrap
);

   logic [BITS-1:0] cnt_q;
   logic [BITS-1:0] cnt_d;

   assign wrap = en && (cnt_q == period);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap ? '0 : cnt_q + BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_scheduler.sv
// Multi-channel PWM generator with double-buffered period/duty configuration.
// New configuration is committed only at a period boundary (or immediately while idle).
module pwm_scheduler
   import pwm_pkg::*;
#(
   parameter int BITS = 8,
   parameter int CH   = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              stop,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [BITS-1:0]   cfg_period,
   input  logic [CH*BITS-1:0] cfg_duty,
   output logic [CH-1:0]     pwm_out,
   output logic [BITS-1:0]   cnt,
   output logic              busy,
   output logic              period_done
);

   pwm_state_e state_q;
   pwm_state_e state_d;

   logic                 pending_q;
   logic                 pending_d;
   logic [BITS-1:0]      shadow_period_q;
   logic [BITS-1:0]      shadow_period_d;
   logic [CH*BITS-1:0]   shadow_duty_q;
   logic [CH*BITS-1:0]   shadow_duty_d;
   logic [BITS-1:0]      active_period_q;
   logic [BITS-1:0]      active_period_d;
   logic [CH*BITS-1:0]   active_duty_q;
   logic [CH*BITS-1:0]   active_duty_d;
   logic                 period_done_q;
   logic                 period_done_d;

   logic idle;
   logic wrap;
   logic cfg_xfer;
   logic commit;

   assign idle        = (state_q == IDLE);
   assign busy        = !idle;
   assign cfg_ready   = !pending_q;
   assign cfg_xfer    = cfg_valid && !pending_q;
   assign period_done = period_done_q;

   pwm_period_counter #(
      .BITS (BITS)
   ) u_counter (
      .clk    (clk),
      .rstn   (rstn),
      .en     (busy),
      .clr    (idle),
      .period (active_period_q),
      .cnt    (cnt),
      .wrap   (wrap)
   );

   // stop beats start in RUN; start beats stop in DRAIN; a stop seen on the wrap cycle ends at once.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (stop) state_d = wrap ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (start) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // commit needs pending_q, so a transfer landing on the wrap edge waits for the next boundary.
   assign commit = pending_q && (idle || wrap);

   always_comb begin
      pending_d       = pending_q;
      shadow_period_d = shadow_period_q;
      shadow_duty_d   = shadow_duty_q;
      active_period_d = active_period_q;
      active_duty_d   = active_duty_q;
      if (commit) begin
         active_period_d = shadow_period_q;
         active_duty_d   = shadow_duty_q;
         pending_d       = 1'b0;
      end
      if (cfg_xfer) begin
         shadow_period_d = cfg_period;
         shadow_duty_d   = cfg_duty;
         pending_d       = 1'b1;
         // While idle nothing is being generated, so the new values can take effect right away.
         if (idle) begin
            active_period_d = cfg_period;
            active_duty_d   = cfg_duty;
         end
      end
   end

   assign period_done_d = wrap && (state_d != IDLE);

   always_comb begin
      pwm_out = '0;
      for (int i = 0; i < CH; i++) begin
         pwm_out[i] = busy && (cnt < active_duty_q[i*BITS +: BITS]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= IDLE;
         pending_q       <= 1'b0;
         shadow_period_q <= {BITS{PERIOD_RST_BIT}};
         shadow_duty_q   <= {(CH*BITS){DUTY_RST_BIT}};
         active_period_q <= {BITS{PERIOD_RST_BIT}};
         active_duty_q   <= {(CH*BITS){DUTY_RST_BIT}};
         period_done_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         pending_q       <= pending_d;
         shadow_period_q <= shadow_period_d;
         shadow_duty_q   <= shadow_duty_d;
         active_period_q <= active_period_d;
         active_duty_q   <= active_duty_d;
         period_done_q   <= period_done_d;
      end
   end

endmodule
